// File: rtl/md_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The master side is the pipeline; the slave side is md_unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             md_start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] md_src_a;
    logic [WIDTH-1:0] md_src_b;
    logic             md_cancel;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    modport master (
        output md_start, md_op, md_src_a, md_src_b, md_cancel,
        input  md_busy, md_done, md_hi, md_lo
    );

    modport slave (
        input  md_start, md_op, md_src_a, md_src_b, md_cancel,
        output md_busy, md_done, md_hi, md_lo
    );
endinterface

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Multiply is right-shifting shift-add; divide is restoring, one quotient bit per cycle.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    md_unit_if.slave    md
);
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               state_r, state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 is_div_r, div_zero_r, neg_q_r, neg_r_r;
    logic [WIDTH-1:0]     a_mag_r, b_mag_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH:0]       rem_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 busy_r, done_r;

    logic                 accept_s, is_arith_s, signed_op_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_trial_s;
    logic                 div_ok_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s, rem_fix_s;

    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            mag_f = ~v + WIDTH'(1);
        end else begin
            mag_f = v;
        end
    endfunction

    // Request decode: a flush in the same cycle suppresses every kind of start.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && md.md_start && !md.md_cancel;
        is_arith_s  = (md.md_op[2] == 1'b0);
        signed_op_s = (md.md_op[0] == 1'b0);
    end

    // One iteration step of each algorithm plus the final sign fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {rem_r[WIDTH-1:0], a_mag_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, b_mag_r};
        div_ok_s    = ~div_trial_s[WIDTH];
        if (neg_q_r) begin
            prod_s = ~acc_r + (2*WIDTH)'(1);
        end else begin
            prod_s = acc_r;
        end
        // A zero divisor leaves the dividend magnitude in rem_r, so re-signing it restores md_src_a.
        if (div_zero_r) begin
            quo_s = {WIDTH{1'b1}};
        end else if (neg_q_r) begin
            quo_s = ~a_mag_r + WIDTH'(1);
        end else begin
            quo_s = a_mag_r;
        end
        if (neg_r_r) begin
            rem_fix_s = ~rem_r[WIDTH-1:0] + WIDTH'(1);
        end else begin
            rem_fix_s = rem_r[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_arith_s) begin
                    state_next_s = ST_ITER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (md.md_cancel) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(ITER - 1)) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_r == ST_FIX) && !md.md_cancel;
        end
    end

    // Operand latch, iteration datapath and HI/LO commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            a_mag_r    <= {WIDTH{1'b0}};
            b_mag_r    <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_arith_s) begin
                        cnt_r      <= {CNT_W{1'b0}};
                        is_div_r   <= md.md_op[1];
                        div_zero_r <= (md.md_src_b == {WIDTH{1'b0}});
                        neg_q_r    <= signed_op_s && (md.md_src_a[WIDTH-1] ^ md.md_src_b[WIDTH-1]);
                        neg_r_r    <= signed_op_s && md.md_src_a[WIDTH-1];
                        a_mag_r    <= mag_f(md.md_src_a, signed_op_s && md.md_src_a[WIDTH-1]);
                        b_mag_r    <= mag_f(md.md_src_b, signed_op_s && md.md_src_b[WIDTH-1]);
                        acc_r      <= {{WIDTH{1'b0}},
                                       mag_f(md.md_src_b, signed_op_s && md.md_src_b[WIDTH-1])};
                        rem_r      <= {(WIDTH+1){1'b0}};
                    end else if (accept_s && (md.md_op == OP_MTHI)) begin
                        hi_r <= md.md_src_a;
                    end else if (accept_s && (md.md_op == OP_MTLO)) begin
                        lo_r <= md.md_src_a;
                    end
                end
                ST_ITER: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (is_div_r) begin
                        rem_r   <= div_ok_s ? div_trial_s : div_shift_s;
                        a_mag_r <= {a_mag_r[WIDTH-2:0], div_ok_s};
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (!md.md_cancel) begin
                        if (is_div_r) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_s;
                        end else begin
                            hi_r <= prod_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    assign md.md_busy = busy_r;
    assign md.md_done = done_r;
    assign md.md_hi   = hi_r;
    assign md.md_lo   = lo_r;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: an arithmetic reference model checked every cycle,
// plus hand-computed HI/LO/done expectations for the directed vectors.
module tb_md_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a countdown of remaining busy cycles and a precomputed result.
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    logic [63:0] m_pend;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: ref_result = sa * sb;
            3'd1: ref_result = ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    ref_result = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {r[31:0], q[31:0]};
                end else begin
                    ref_result = {(ua % ub), 32'd0} | {32'd0, (ua / ub) & 64'h0000_0000_FFFF_FFFF};
                end
            end
            default: ref_result = 64'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_done <= 1'b0;
            m_pend <= 64'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (bus.md_start && !bus.md_cancel) begin
                    case (bus.md_op)
                        3'd4: m_hi <= bus.md_src_a;
                        3'd5: m_lo <= bus.md_src_a;
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            m_pend <= ref_result(bus.md_op, bus.md_src_a, bus.md_src_b);
                            m_left <= 33;
                        end
                        default: ;
                    endcase
                end
            end else if (bus.md_cancel) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Literal-expectation requests from the stimulus, serviced by the compare process.
    int          lit_req = 0;
    int          lit_ack = 0;
    string       lit_name;
    logic [31:0] lit_hi, lit_lo;
    int          lit_dd;
    logic        lit_busy;
    int          done_total = 0;
    int          done_base = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("busy", {63'd0, bus.md_busy}, {63'd0, (m_left != 0)});
            cmp("done", {63'd0, bus.md_done}, {63'd0, m_done});
            cmp("hi", {32'd0, bus.md_hi}, {32'd0, m_hi});
            cmp("lo", {32'd0, bus.md_lo}, {32'd0, m_lo});
            if (bus.md_done === 1'b1) begin
                done_total++;
            end
            if (lit_ack != lit_req) begin
                cmp({lit_name, "_hi"}, {32'd0, bus.md_hi}, {32'd0, lit_hi});
                cmp({lit_name, "_lo"}, {32'd0, bus.md_lo}, {32'd0, lit_lo});
                cmp({lit_name, "_busy"}, {63'd0, bus.md_busy}, {63'd0, lit_busy});
                cmp({lit_name, "_done_count"}, 64'(done_total - done_base), 64'(lit_dd));
                done_base = done_total;
                lit_ack   = lit_req;
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] h, input logic [31:0] l,
                       input int dd, input logic bz);
        lit_name = nm;
        lit_hi   = h;
        lit_lo   = l;
        lit_dd   = dd;
        lit_busy = bz;
        lit_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.md_start = 1'b1;
        bus.md_op    = op;
        bus.md_src_a = a;
        bus.md_src_b = b;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        while (m_left != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.md_start  = 1'b0;
        bus.md_op     = 3'd6;
        bus.md_src_a  = 32'd0;
        bus.md_src_b  = 32'd0;
        bus.md_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lit("reset", 32'd0, 32'd0, 0, 1'b0);

        // Back-to-back MTHI then MTLO.
        @(posedge clk);
        #1;
        bus.md_start = 1'b1; bus.md_op = 3'd4; bus.md_src_a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.md_op = 3'd5; bus.md_src_a = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
        lit("mthi_mtlo", 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1'b0);

        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        lit("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        lit("multu", 32'h0000_0002, 32'hFFFF_FFFA, 1, 1'b0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
        lit("mult_min", 32'h4000_0000, 32'h0000_0000, 1, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        lit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1'b0);
        run_op(3'd3, 32'h0000_0007, 32'h0000_0002);
        lit("divu", 32'h0000_0001, 32'h0000_0003, 1, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        lit("div_ovf", 32'h0000_0000, 32'h8000_0000, 1, 1'b0);
        run_op(3'd3, 32'h1234_5678, 32'h0000_0000);
        lit("divu_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
        lit("div_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 1'b0);

        // Flush together with MTHI in IDLE suppresses the write.
        @(posedge clk);
        #1;
        bus.md_start = 1'b1; bus.md_op = 3'd4; bus.md_src_a = 32'h5555_AAAA; bus.md_cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0; bus.md_cancel = 1'b0;
        lit("cancel_mthi", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 1'b0);

        // Start while busy is dropped; cancel aborts without committing.
        start_op(3'd0, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        bus.md_start = 1'b1; bus.md_op = 3'd1; bus.md_src_a = 32'd9; bus.md_src_b = 32'd9;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.md_cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.md_cancel = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        lit("cancel", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 1'b0);

        // Asynchronous reset in the middle of a divide.
        start_op(3'd3, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        lit("reset_mid", 32'd0, 32'd0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        lit("after_reset", 32'd0, 32'd0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
